// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with single-cycle add/sub/shift and bit-serial multiply/divide
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] input_a_i,
  input  logic [WIDTH-1:0] input_b_i,
  output logic [WIDTH-1:0] out1_o,
  output logic [WIDTH-1:0] out2_o,
  output logic             zero_o,
  output logic             div_by_zero_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'b010, OP_SUB = 3'b011, OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101, OP_SHL = 3'b110, OP_SHR = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d, out1_q, out1_d, out2_q, out2_d;
  logic is_div_q, is_div_d, zero_q, zero_d, dbz_q, dbz_d;
  logic [WIDTH:0] sum, mul_sum, shifted;
  logic [WIDTH-1:0] diff, shl, shr, r1, r2, rem_n;
  logic [2*WIDTH-1:0] mul_n, div_n, step;
  logic ge, iter;
  assign sum = {1'b0, input_a_i} + {1'b0, input_b_i};
  assign diff = input_a_i - input_b_i;
  assign shl = input_b_i >= WIDTH'(WIDTH) ? '0 : input_a_i << input_b_i;
  assign shr = input_b_i >= WIDTH'(WIDTH) ? '0 : input_a_i >> input_b_i;
  assign r1 = op_i == OP_ADD ? sum[WIDTH-1:0] : op_i == OP_SUB ? diff :
              op_i == OP_SHL ? shl : op_i == OP_SHR ? shr : op_i == OP_DIV ? '1 : '0;
  assign r2 = op_i == OP_ADD ? {{(WIDTH-1){1'b0}}, sum[WIDTH]} :
              op_i == OP_SUB ? {{(WIDTH-1){1'b0}}, input_a_i < input_b_i} :
              op_i == OP_DIV ? input_a_i : '0;
  assign iter = op_i == OP_MUL || (op_i == OP_DIV && input_b_i != '0);
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_n = p_q[0] ? {mul_sum, p_q[WIDTH-1:1]} : {1'b0, p_q[2*WIDTH-1:1]};
  assign shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign ge = shifted >= {1'b0, b_q};
  assign rem_n = ge ? shifted[WIDTH-1:0] - b_q : shifted[WIDTH-1:0];
  assign div_n = {rem_n, p_q[WIDTH-2:0], ge};
  assign step = is_div_q ? div_n : mul_n;
  // next-state: iterate in RUN, accept new work in IDLE/DONE, drop back to IDLE after one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    p_d = p_q;
    b_d = b_q;
    is_div_d = is_div_q;
    out1_d = out1_q;
    out2_d = out2_q;
    zero_d = zero_q;
    dbz_d = dbz_q;
    if (state_q == RUN) begin
      p_d = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        out1_d = step[WIDTH-1:0];
        out2_d = step[2*WIDTH-1:WIDTH];
        zero_d = step[WIDTH-1:0] == '0;
        dbz_d = 1'b0;
      end
    end else if (start_i) begin
      if (iter) begin
        state_d = RUN;
        cnt_d = CW'(WIDTH);
        p_d = {{WIDTH{1'b0}}, input_a_i};
        b_d = input_b_i;
        is_div_d = op_i == OP_DIV;
      end else begin
        state_d = DONE;
        out1_d = r1;
        out2_d = r2;
        zero_d = r1 == '0;
        dbz_d = op_i == OP_DIV;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and result registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      p_q <= '0;
      b_q <= '0;
      is_div_q <= 1'b0;
      out1_q <= '0;
      out2_q <= '0;
      zero_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      b_q <= b_d;
      is_div_q <= is_div_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
      zero_q <= zero_d;
      dbz_q <= dbz_d;
    end
  end
  assign out1_o = out1_q;
  assign out2_o = out2_q;
  assign zero_o = zero_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with a queued scoreboard checked whenever Done pulses
module tb_seq_alu;
  logic clk = 0, rst_n = 0, start = 0;
  logic [2:0] op = 0;
  logic [15:0] a = 0, b = 0, out1, out2;
  logic zero, dbz, busy, done;
  int vec = 0, fail = 0, cyc = 0, bcnt = 0;
  typedef struct {int due; logic [15:0] o1, o2; logic z, d; int busy;} exp_t;
  exp_t sb[$];

  seq_alu #(.WIDTH(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .op_i(op),
    .input_a_i(a), .input_b_i(b), .out1_o(out1), .out2_o(out2),
    .zero_o(zero), .div_by_zero_o(dbz), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) bcnt = 0;
    else begin
      if (busy) bcnt++;
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("out1", out1, e.o1);
          chk("out2", out2, e.o2);
          chk("zero", zero, e.z);
          chk("divbyzero", dbz, e.d);
          chk("busy_cycles", bcnt, e.busy);
        end
        bcnt = 0;
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("done_timeout", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] e1, input logic [15:0] e2, input logic ez,
                       input logic ed, input int iters);
    exp_t e;
    op = o; a = x; b = y; start = 1;
    e.due = cyc + 1 + iters; e.o1 = e1; e.o2 = e2; e.z = ez; e.d = ed; e.busy = iters;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    start = 0;
  endtask

  task automatic poke(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    op = o; a = x; b = y; start = 1;
    @(posedge clk); @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic settle();
    wait_done();
    @(negedge clk);
  endtask

  task automatic chk_zeroed(string tag);
    chk({tag, "_out1"}, out1, 0);
    chk({tag, "_out2"}, out2, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_dbz"}, dbz, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1 chk_zeroed("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(3'b010, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1, 0, 0); settle();
    issue(3'b100, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 0, 0, 16); settle();
    issue(3'b101, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 16); settle();
    issue(3'b101, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 16); settle();
    issue(3'b101, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 0, 1, 0); settle();
    issue(3'b010, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 0, 0, 0); settle();
    issue(3'b011, 16'h0005, 16'h0007, 16'hFFFE, 16'h0001, 0, 0, 0); settle();
    issue(3'b011, 16'h0007, 16'h0007, 16'h0000, 16'h0000, 1, 0, 0); settle();
    issue(3'b001, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1, 0, 0); settle();
    issue(3'b100, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 16); settle();
    issue(3'b101, 16'hFFFF, 16'h00FF, 16'h0101, 16'h0000, 0, 0, 16); settle();
    issue(3'b100, 16'd3, 16'd5, 16'd15, 16'd0, 0, 0, 16);
    repeat (3) @(negedge clk);
    poke(3'b101, 16'd9, 16'd3);
    wait_done();
    issue(3'b011, 16'd10, 16'd3, 16'd7, 16'd0, 0, 0, 0);
    wait_done();
    issue(3'b110, 16'h00F0, 16'd4, 16'h0F00, 16'h0000, 0, 0, 0); settle();
    poke(3'b101, 16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    rst_n = 0;
    #1 chk_zeroed("abort");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    issue(3'b110, 16'h0001, 16'd16, 16'h0000, 16'h0000, 1, 0, 0); settle();
    issue(3'b111, 16'h8000, 16'd15, 16'h0001, 16'h0000, 0, 0, 0); settle();
    repeat (25) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end
endmodule
